// File: rtl/gpu_pkg.sv
// Shared types and field layout for the line scheduler slice.
package gpu_pkg;

    localparam int unsigned POS_W  = 38;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned CNT_W  = 16;

    localparam int unsigned START_X_LSB = 28;
    localparam int unsigned START_Y_LSB = 19;
    localparam int unsigned END_X_LSB   = 9;
    localparam int unsigned END_Y_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_DRAW,
        ST_STALL
    } sched_state_e;

    typedef struct packed {
        logic [X_W-1:0] start_x;
        logic [Y_W-1:0] start_y;
        logic [X_W-1:0] end_x;
        logic [Y_W-1:0] end_y;
    } line_cmd_t;

endpackage

// File: rtl/line_sched_if.sv
// Command, engine and frame-buffer signals of the line scheduler.
interface line_sched_if;
    import gpu_pkg::*;

    logic              cmd_valid;
    logic [POS_W-1:0]  cmd_positions;
    logic              cmd_ready;
    logic [POS_W-1:0]  eng_positions;
    logic              eng_start;
    logic              eng_stop;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_done;
    logic              fb_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic              busy;
    logic [CNT_W-1:0]  lines_drawn;

    // Environment side: command source, line engine and frame buffer.
    modport master (
        output cmd_valid, cmd_positions, eng_addr, eng_done, fb_ready,
        input  cmd_ready, eng_positions, eng_start, eng_stop, fb_we, fb_addr,
               busy, lines_drawn
    );

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_positions, eng_addr, eng_done, fb_ready,
        output cmd_ready, eng_positions, eng_start, eng_stop, fb_we, fb_addr,
               busy, lines_drawn
    );

endinterface

// File: rtl/line_sched_cmd_fifo.sv
// Command FIFO with registered occupancy; full stays asserted in a popping cycle.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + OCC_W'(1);
            else if (do_pop && !do_push) count <= count - OCC_W'(1);
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/line_sched.sv
// Queues line commands and sequences the line engine against frame-buffer backpressure.
module line_sched
    import gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    line_sched_if.slave bus
);

    sched_state_e     state;
    sched_state_e     state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             avail;
    logic             complete;
    logic             stop_c;
    logic [POS_W-1:0] head;
    logic [POS_W-1:0] pos_q;
    logic [CNT_W-1:0] lines_q;
    logic             start_q;
    logic             we_q;

    // A command arriving this cycle counts as queued work so an idle scheduler launches next cycle.
    assign push  = bus.cmd_valid && !fifo_full;
    assign pop   = (state == ST_LAUNCH);
    assign avail = !fifo_empty || push;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (POS_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.cmd_positions),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, engine freeze and line completion.
    always_comb begin
        state_nxt = state;
        stop_c    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (avail) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_nxt = ST_DRAW;
            end
            ST_DRAW, ST_STALL: begin
                if (!bus.fb_ready) begin
                    stop_c    = 1'b1;
                    state_nxt = ST_STALL;
                end else if (bus.eng_done) begin
                    complete  = 1'b1;
                    state_nxt = avail ? ST_LAUNCH : ST_IDLE;
                end else begin
                    state_nxt = ST_DRAW;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered launch pulse, write strobe, segment and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            we_q    <= 1'b0;
            pos_q   <= '0;
            lines_q <= '0;
        end else begin
            start_q <= (state_nxt == ST_LAUNCH);
            we_q    <= (state_nxt == ST_DRAW) || (state_nxt == ST_STALL);
            if (pop)      pos_q   <= head;
            if (complete) lines_q <= lines_q + CNT_W'(1);
        end
    end

    assign bus.cmd_ready     = !fifo_full;
    assign bus.eng_positions = pos_q;
    assign bus.eng_start     = start_q;
    assign bus.eng_stop      = stop_c;
    assign bus.fb_we         = we_q;
    assign bus.fb_addr       = bus.eng_addr;
    assign bus.busy          = !fifo_empty || (state != ST_IDLE);
    assign bus.lines_drawn   = lines_q;

endmodule
